rr_priority_arbiter: RTL

- Parametrised N-requester arbiter built on a priority-encoding core. Adds registered grants, grant hold (ownership) and a selectable fixed-priority or round-robin mode.
- Sits between N requesting masters and one shared resource (bus, FIFO write port, memory).
- The owner keeps the grant until it drops its request. Outputs are one-hot grant, binary index and valid.

---
 rtl/rr_arb_pkg.sv | 15 +
 rtl/rr_priority_arbiter_if.sv | 29 ++
 rtl/rr_priority_arbiter_prio_pick.sv | 24 ++
 rtl/rr_priority_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared encodings for the round-robin / fixed-priority arbiter.
// Optional feature macro: ARB_HOLD_TIMEOUT_EN (hold-time limit).
package rr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int HOLD_CW = 8;

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Requester-side bundle: mode, request vector and registered grant outputs.
// master = requester side, slave = arbiter side.
interface rr_priority_arbiter_if #(
    parameter int N = 4
) ();
    localparam int IDXW = $clog2(N);

    logic            mode;
    logic [N-1:0]    req;
    logic [N-1:0]    gnt;
    logic [IDXW-1:0] gnt_idx;
    logic            gnt_valid;

    modport master (
        output mode,
        output req,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  mode,
        input  req,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_priority_arbiter_prio_pick.sv
// Combinational lowest-index picker over an N-bit vector.
// found is low and idx is 0 when the vector is empty.
module prio_pick #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    vec_i,
    output logic [IDXW-1:0] idx_o,
    output logic            found_o
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDXW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-requester arbiter with grant ownership, fixed/round-robin modes.
// Optional feature macro: ARB_HOLD_TIMEOUT_EN (force re-arbitration after MAX_HOLD cycles).
module rr_priority_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_priority_arbiter_if.slave arb
);

    localparam int IDXW = $clog2(N);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_priority_arbiter: N must be within 2..32");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_priority_arbiter: MAX_HOLD must be within 1..255");
    end

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;

    logic            owner_req;
    logic            release_w;
    logic            arb_w;
    logic [N-1:0]    cand;
    logic [N-1:0]    masked;
    logic [IDXW-1:0] m_idx, r_idx, win;
    logic            m_found, r_found;

`ifdef ARB_HOLD_TIMEOUT_EN
    logic [HOLD_CW-1:0] hold_cnt_q, hold_cnt_d;
    logic               force_w;
    logic [N-1:0]       others;
`endif

    // Decide whether this cycle is an arbitration point and which requests compete
    always_comb begin
        owner_req = arb.req[idx_q];
        release_w = (state_q == ST_OWNED) && !owner_req;
`ifdef ARB_HOLD_TIMEOUT_EN
        force_w = (state_q == ST_OWNED) && owner_req
                  && (hold_cnt_q == HOLD_CW'(MAX_HOLD - 1));
        others  = arb.req & ~gnt_q;
        // Owner steps aside for one pick, unless nobody else is asking
        cand    = (force_w && (|others)) ? others : arb.req;
        arb_w   = (state_q == ST_IDLE) || release_w || force_w;
`else
        cand    = arb.req;
        arb_w   = (state_q == ST_IDLE) || release_w;
`endif
        for (int i = 0; i < N; i++) begin
            masked[i] = cand[i] && (i >= int'(rr_ptr_q));
        end
    end

    prio_pick #(.N(N), .IDXW(IDXW)) u_pick_masked (
        .vec_i   (masked),
        .idx_o   (m_idx),
        .found_o (m_found)
    );

    prio_pick #(.N(N), .IDXW(IDXW)) u_pick_raw (
        .vec_i   (cand),
        .idx_o   (r_idx),
        .found_o (r_found)
    );

    // Round robin falls back to the raw pick when nothing sits at or above rr_ptr
    always_comb begin
        win = r_idx;
        if (arb.mode == MODE_RR && m_found) begin
            win = m_idx;
        end
    end

    // Next-state: hold the owner, hand off, or drop to idle
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
`ifdef ARB_HOLD_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q + HOLD_CW'(1);
`endif
        if (arb_w) begin
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_d = '0;
`endif
            if (r_found) begin
                state_d    = ST_OWNED;
                gnt_d      = '0;
                gnt_d[win] = 1'b1;
                idx_d      = win;
                valid_d    = 1'b1;
                rr_ptr_d   = (win == IDXW'(N - 1)) ? '0 : win + IDXW'(1);
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    // Grant FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            rr_ptr_q <= '0;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
`endif
        end
    end

    assign arb.gnt       = gnt_q;
    assign arb.gnt_idx   = idx_q;
    assign arb.gnt_valid = valid_q;

endmodule
